prg_loader: RTL and testbench



---
 rtl/prg_loader_pkg.sv | 25 ++
 rtl/prg_loader_timeout.sv | 38 +++
 rtl/prg_loader.sv | 197 +++++++++++++++++++
 tb/tb_prg_loader.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prg_loader_pkg.sv
// Shared definitions for the program loader.
//   state_e        : frame parser states
//   SYNC_BYTE      : frame start marker
//   LEN_ZERO_MEANS : byte count encoded by a length field of zero
//   csum_step      : one step of the 8-bit additive frame checksum
package prg_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddrHi,
        StAddrLo,
        StLen,
        StData,
        StCsum,
        StResp
    } state_e;

    localparam logic [7:0]  SYNC_BYTE      = 8'hA5;
    localparam int unsigned LEN_ZERO_MEANS = 256;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/prg_loader_timeout.sv
// Mid-frame inactivity timer for the program loader.
//   clk, reset_n : clock, synchronous active-low reset
//   clear        : restart the count from zero (an accepted byte)
//   enable       : count this cycle (a frame is in progress)
//   expire       : TIMEOUT_CYCLES enabled cycles have elapsed since the last clear
// TIMEOUT_CYCLES = 0 removes the counter and expire is tied low.
module prg_loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    if (TIMEOUT_CYCLES == 0) begin : g_off
        logic unused_inputs;
        assign unused_inputs = ^{clk, reset_n, clear, enable};
        assign expire        = 1'b0;
    end else begin : g_on
        localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

        logic [CW-1:0] count_q;

        // Fires on the cycle whose edge would complete the TIMEOUT_CYCLES-th idle cycle.
        assign expire = enable && !clear && (count_q == CW'(TIMEOUT_CYCLES - 1));

        always_ff @(posedge clk) begin
            if (!reset_n || clear) begin
                count_q <= '0;
            end else if (enable && !expire) begin
                count_q <= count_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/prg_loader.sv
// Byte-stream program loader feeding the program RAM write port.
// Parses frames: A5, addr_hi, addr_lo, len (0 = 256), len data bytes[, checksum].
//   clk, reset_n          : clock, synchronous active-low reset
//   in_data/in_valid      : byte source; in_ready marks the accepting cycle
//   mem_addr/data/we      : RAM write port, one write the cycle after each data byte
//   cpu_hold              : high while a frame is in progress
//   done / err            : one-cycle frame result pulses
//   bytes_written         : saturating count of data bytes written since reset
// Build option: define PRG_LOADER_CHECKSUM_EN to require a trailing checksum byte.
module prg_loader
    import prg_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_data,
    output logic                  mem_we,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           bytes_written
);

    if (DATA_WIDTH != 8) begin : g_bad_data_width
        $error("prg_loader: DATA_WIDTH must be 8");
    end

    state_e                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic [7:0]            addr_hi_q, addr_hi_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [8:0]            cnt_q, cnt_d;
    logic                  ok_q, ok_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_data_q, mem_data_d;
    logic [15:0]           bw_q, bw_d;

    logic accept;
    logic tmo_enable;
    logic tmo_expire;

    assign accept     = in_valid && in_ready_q;
    assign tmo_enable = (state_q != StIdle) && (state_q != StResp);

    prg_loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept),
        .enable  (tmo_enable),
        .expire  (tmo_expire)
    );

`ifdef PRG_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    // Running sum of every header and data byte; the checksum byte must bring it to zero.
    always_comb begin
        csum_d = csum_q;
        if (accept) begin
            case (state_q)
                StAddrHi:               csum_d = in_data;
                StAddrLo, StLen, StData: csum_d = csum_step(csum_q, in_data);
                default:                 csum_d = csum_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        addr_hi_d  = addr_hi_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        ok_d       = ok_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        bw_d       = bw_q;

        case (state_q)
            StIdle: begin
                if (accept && in_data == SYNC_BYTE) begin
                    state_d = StAddrHi;
                end
            end
            StAddrHi: begin
                if (accept) begin
                    addr_hi_d = in_data;
                    state_d   = StAddrLo;
                end
            end
            StAddrLo: begin
                if (accept) begin
                    ptr_d   = ADDR_WIDTH'({addr_hi_q, in_data});
                    state_d = StLen;
                end
            end
            StLen: begin
                if (accept) begin
                    cnt_d   = (in_data == 8'h00) ? 9'(LEN_ZERO_MEANS) : {1'b0, in_data};
                    state_d = StData;
                end
            end
            StData: begin
                if (accept) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = ptr_q;
                    mem_data_d = in_data;
                    ptr_d      = ptr_q + ADDR_WIDTH'(1);
                    cnt_d      = cnt_q - 9'd1;
                    if (bw_q != 16'hFFFF) begin
                        bw_d = bw_q + 16'd1;
                    end
                    if (cnt_q == 9'd1) begin
`ifdef PRG_LOADER_CHECKSUM_EN
                        state_d = StCsum;
`else
                        state_d = StResp;
                        ok_d    = 1'b1;
`endif
                    end
                end
            end
`ifdef PRG_LOADER_CHECKSUM_EN
            StCsum: begin
                if (accept) begin
                    ok_d    = (csum_step(csum_q, in_data) == 8'h00);
                    state_d = StResp;
                end
            end
`endif
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (tmo_expire) begin
            state_d = StResp;
            ok_d    = 1'b0;
        end

        in_ready_d = (state_d != StResp);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            in_ready_q <= 1'b0;
            addr_hi_q  <= 8'h00;
            ptr_q      <= '0;
            cnt_q      <= 9'd0;
            ok_q       <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= 8'h00;
            bw_q       <= 16'h0000;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            addr_hi_q  <= addr_hi_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            ok_q       <= ok_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            bw_q       <= bw_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_data      = mem_data_q;
    assign bytes_written = bw_q;
    assign cpu_hold      = (state_q != StIdle);
    assign done          = (state_q == StResp) && ok_q;
    assign err           = (state_q == StResp) && !ok_q;

endmodule

// File: tb/tb_prg_loader.sv
// Self-checking bench for prg_loader (ADDR_WIDTH=8, TIMEOUT_CYCLES=50).
// Expected RAM writes are derived from the frame contents; a monitor logs what the DUT does.
module tb_prg_loader;

    localparam int unsigned AW = 8;
    localparam int unsigned TO = 50;
`ifdef PRG_LOADER_CHECKSUM_EN
    localparam int CSUM_BYTES = 1;
`else
    localparam int CSUM_BYTES = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_we;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [15:0]   bytes_written;

    prg_loader #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .mem_we        (mem_we),
        .cpu_hold      (cpu_hold),
        .done          (done),
        .err           (err),
        .bytes_written (bytes_written)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t wq[$];
    int  cyc     = 0;
    int  done_n  = 0;
    int  err_n   = 0;
    int  err_cyc = 0;
    int  total   = 0;
    int  bad     = 0;
    int  acc_cyc = 0;
    int  model_bw = 0;
    int  hold_low = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we === 1'b1) wq.push_back('{cyc, mem_addr, mem_data});
        if (done === 1'b1) done_n <= done_n + 1;
        if (err === 1'b1) begin
            err_n   <= err_n + 1;
            err_cyc <= cyc;
        end
    end

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic push_byte(input logic [7:0] b);
        int waits;
        waits    = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL push_byte: in_ready=%b after %0d cycles, required 1", in_ready, waits);
        end
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [7:0] len_b,
                              input logic [7:0] d[$], input int gap_max);
        logic [7:0] bytes[$];
`ifdef PRG_LOADER_CHECKSUM_EN
        logic [7:0] sum;
`endif
        bytes.push_back(8'hA5);
        bytes.push_back(a[15:8]);
        bytes.push_back(a[7:0]);
        bytes.push_back(len_b);
        foreach (d[i]) bytes.push_back(d[i]);
`ifdef PRG_LOADER_CHECKSUM_EN
        sum = a[15:8] + a[7:0] + len_b;
        foreach (d[i]) sum = sum + d[i];
        bytes.push_back(8'h00 - sum);
`endif
        hold_low = 0;
        foreach (bytes[i]) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
            push_byte(bytes[i]);
            if (cpu_hold !== 1'b1) hold_low++;
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        total++;
        if ({in_ready, mem_we, cpu_hold, done, err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: ready/we/hold/done/err=%b, required 00000",
                     {in_ready, mem_we, cpu_hold, done, err});
        end
        total++;
        if (mem_addr !== 8'h00 || mem_data !== 8'h00 || bytes_written !== 16'h0000) begin
            bad++;
            $display("FAIL reset_values: addr=%h data=%h bw=%h, required 00 00 0000",
                     mem_addr, mem_data, bytes_written);
        end
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: in_ready=%b cpu_hold=%b, required 1 0", in_ready, cpu_hold);
        end
        model_bw = 0;
    endtask

    task automatic test_basic();
        logic [7:0] d[$];
        int w0, d0, last;
        d  = '{8'h11, 8'h22, 8'h33};
        w0 = wq.size();
        d0 = done_n;
        send_frame(16'h0010, 8'h03, d, 0);
        last = acc_cyc - CSUM_BYTES;
        total++;
        if (done !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_resp: done=%b in_ready=%b, required 1 0", done, in_ready);
        end
        total++;
        if (hold_low !== 0) begin
            bad++;
            $display("FAIL basic_hold: cpu_hold low on %0d frame cycles, required 0", hold_low);
        end
        model_bw += 3;
        total++;
        if (bytes_written !== 16'(model_bw)) begin
            bad++;
            $display("FAIL basic_bw: bytes_written=%0d, required %0d", bytes_written, model_bw);
        end
        #1;
        total++;
        if (wq.size() - w0 !== 3) begin
            bad++;
            $display("FAIL basic_nwrites: writes=%0d, required 3", wq.size() - w0);
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (wq[w0+k].a !== 8'(16 + k) || wq[w0+k].d !== d[k] || wq[w0+k].t !== last - 2 + k) begin
                    bad++;
                    $display("FAIL basic_write%0d: addr=%h data=%h cyc=%0d, required %h %h %0d", k,
                             wq[w0+k].a, wq[w0+k].d, wq[w0+k].t, 8'(16 + k), d[k], last - 2 + k);
                end
            end
        end
        @(negedge clk);
        total++;
        if (cpu_hold !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1 || done_n - d0 !== 1) begin
            bad++;
            $display("FAIL basic_after: hold=%b done=%b ready=%b pulses=%0d, required 0 0 1 1",
                     cpu_hold, done, in_ready, done_n - d0);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] d[$];
        int w0, d0, nbad, fk;
        for (int i = 0; i < 256; i++) d.push_back(8'($urandom));
        w0 = wq.size();
        d0 = done_n;
        send_frame(16'h00FE, 8'h00, d, 0);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL wrap_done: done=%b, required 1", done);
        end
        model_bw += 256;
        total++;
        if (bytes_written !== 16'(model_bw)) begin
            bad++;
            $display("FAIL wrap_bw: bytes_written=%0d, required %0d", bytes_written, model_bw);
        end
        #1;
        total++;
        if (wq.size() - w0 !== 256) begin
            bad++;
            $display("FAIL wrap_nwrites: writes=%0d, required 256", wq.size() - w0);
        end else begin
            nbad = 0;
            fk   = 0;
            for (int k = 0; k < 256; k++) begin
                if (wq[w0+k].a !== 8'((254 + k) % 256) || wq[w0+k].d !== d[k] ||
                    wq[w0+k].t !== wq[w0].t + k) begin
                    if (nbad == 0) fk = k;
                    nbad++;
                end
            end
            total++;
            if (nbad !== 0) begin
                bad++;
                $display("FAIL wrap_writes: %0d wrong, first k=%0d addr=%h data=%h, required %h %h",
                         nbad, fk, wq[w0+fk].a, wq[w0+fk].d, 8'((254 + fk) % 256), d[fk]);
            end
        end
        total++;
        if (done_n - d0 !== 1) begin
            bad++;
            $display("FAIL wrap_pulses: done pulses=%0d, required 1", done_n - d0);
        end
    endtask

    task automatic test_garbage();
        logic [7:0] g[3];
        logic [7:0] d[$];
        int w0;
        g  = '{8'h00, 8'hFF, 8'h13};
        w0 = wq.size();
        for (int i = 0; i < 3; i++) begin
            push_byte(g[i]);
            total++;
            if (cpu_hold !== 1'b0) begin
                bad++;
                $display("FAIL garbage_hold%0d: cpu_hold=%b, required 0", i, cpu_hold);
            end
        end
        d = '{8'h77};
        send_frame(16'h0020, 8'h01, d, 0);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL garbage_done: done=%b, required 1", done);
        end
        model_bw += 1;
        #1;
        total++;
        if (wq.size() - w0 !== 1 || wq[wq.size()-1].a !== 8'h20 || wq[wq.size()-1].d !== 8'h77) begin
            bad++;
            $display("FAIL garbage_write: writes=%0d last=%h:%h, required 1 20:77",
                     wq.size() - w0, wq[wq.size()-1].a, wq[wq.size()-1].d);
        end
    endtask

    task automatic test_sync_in_data();
        logic [7:0] d[$];
        int w0;
        d  = '{8'hA5, 8'hA5};
        w0 = wq.size();
        send_frame(16'h0030, 8'h02, d, 0);
        model_bw += 2;
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL syncdata_done: done=%b, required 1", done);
        end
        #1;
        total++;
        if (wq.size() - w0 !== 2 || wq[w0].a !== 8'h30 || wq[w0+1].a !== 8'h31 ||
            wq[w0].d !== 8'hA5 || wq[w0+1].d !== 8'hA5) begin
            bad++;
            $display("FAIL syncdata_writes: n=%0d, required 2 writes of A5 at 30,31", wq.size() - w0);
        end
    endtask

`ifdef PRG_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] fr[6];
        logic [7:0] d[$];
        int w0;
        d = '{8'h5A};
        send_frame(16'h0000, 8'h01, d, 0);
        model_bw += 1;
        total++;
        if (done !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL csum_good: done=%b err=%b, required 1 0", done, err);
        end
        fr = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h5A, 8'h00};
        w0 = wq.size();
        for (int i = 0; i < 6; i++) push_byte(fr[i]);
        model_bw += 1;
        total++;
        if (done !== 1'b0 || err !== 1'b1) begin
            bad++;
            $display("FAIL csum_bad: done=%b err=%b, required 0 1", done, err);
        end
        #1;
        total++;
        if (wq.size() - w0 !== 1 || wq[w0].a !== 8'h00 || wq[w0].d !== 8'h5A) begin
            bad++;
            $display("FAIL csum_bad_write: n=%0d, required RAM[00]=5A written", wq.size() - w0);
        end
    endtask
`endif

    task automatic test_timeout();
        logic [7:0] fr[6];
        logic [7:0] d[$];
        int w0, d0, e0, last;
        fr = '{8'hA5, 8'h00, 8'h00, 8'h04, 8'h01, 8'h02};
        w0 = wq.size();
        d0 = done_n;
        e0 = err_n;
        for (int i = 0; i < 6; i++) push_byte(fr[i]);
        last = acc_cyc;
        for (int k = 0; k < 200 && err_n == e0; k++) @(negedge clk);
        #1;
        total++;
        if (err_n - e0 !== 1 || done_n - d0 !== 0) begin
            bad++;
            $display("FAIL timeout_pulse: err pulses=%0d done pulses=%0d, required 1 0",
                     err_n - e0, done_n - d0);
        end else begin
            total++;
            if (err_cyc !== last + int'(TO)) begin
                bad++;
                $display("FAIL timeout_cycle: err at cycle %0d, required %0d", err_cyc, last + int'(TO));
            end
        end
        model_bw += 2;
        total++;
        if (wq.size() - w0 !== 2 || wq[w0].a !== 8'h00 || wq[w0].d !== 8'h01 ||
            wq[w0+1].a !== 8'h01 || wq[w0+1].d !== 8'h02 || bytes_written !== 16'(model_bw)) begin
            bad++;
            $display("FAIL timeout_writes: n=%0d bw=%0d, required 2 writes 00:01 01:02 bw=%0d",
                     wq.size() - w0, bytes_written, model_bw);
        end
        @(negedge clk);
        total++;
        if (cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL timeout_hold: cpu_hold=%b, required 0", cpu_hold);
        end
        d  = '{8'h99};
        w0 = wq.size();
        send_frame(16'h0040, 8'h01, d, 0);
        model_bw += 1;
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL timeout_next_done: done=%b, required 1", done);
        end
        #1;
        total++;
        if (wq.size() - w0 !== 1 || wq[w0].a !== 8'h40 || wq[w0].d !== 8'h99) begin
            bad++;
            $display("FAIL timeout_next_write: n=%0d, required RAM[40]=99", wq.size() - w0);
        end
    endtask

    task automatic test_random();
        int d0, e0;
        d0 = done_n;
        e0 = err_n;
        for (int f = 0; f < 16; f++) begin
            int         len, ng, w0, nbad;
            logic [15:0] a;
            logic [7:0]  g;
            logic [7:0]  d[$];
            len = $urandom_range(1, 12);
            a   = 16'($urandom);
            for (int i = 0; i < len; i++) d.push_back(8'($urandom));
            ng = $urandom_range(0, 2);
            for (int i = 0; i < ng; i++) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h3C;
                push_byte(g);
            end
            w0 = wq.size();
            send_frame(a, 8'(len), d, 2);
            model_bw += len;
            total++;
            if (done !== 1'b1 || hold_low !== 0 || bytes_written !== 16'(model_bw)) begin
                bad++;
                $display("FAIL rand%0d_resp: done=%b hold_low=%0d bw=%0d, required 1 0 %0d",
                         f, done, hold_low, bytes_written, model_bw);
            end
            #1;
            nbad = 0;
            if (wq.size() - w0 != len) begin
                nbad = -1;
            end else begin
                for (int k = 0; k < len; k++) begin
                    if (wq[w0+k].a !== 8'((int'(a[7:0]) + k) % 256) || wq[w0+k].d !== d[k]) nbad++;
                end
            end
            total++;
            if (nbad !== 0) begin
                bad++;
                $display("FAIL rand%0d_writes: writes=%0d wrong=%0d, required %0d writes from %h",
                         f, wq.size() - w0, nbad, len, a[7:0]);
            end
        end
        total++;
        if (done_n - d0 !== 16 || err_n - e0 !== 0) begin
            bad++;
            $display("FAIL rand_pulses: done=%0d err=%0d, required 16 0", done_n - d0, err_n - e0);
        end
    endtask

    task automatic test_midreset();
        logic [7:0] fr[6];
        logic [7:0] d[$];
        int rc, late;
        fr = '{8'hA5, 8'h00, 8'h50, 8'h05, 8'h01, 8'h02};
        for (int i = 0; i < 6; i++) push_byte(fr[i]);
        in_valid = 1'b1;
        in_data  = 8'h03;
        reset_n  = 1'b0;
        @(negedge clk);
        rc = cyc;
        total++;
        if ({in_ready, mem_we, cpu_hold, done, err} !== 5'b0 || mem_addr !== 8'h00 ||
            mem_data !== 8'h00 || bytes_written !== 16'h0000) begin
            bad++;
            $display("FAIL midreset_clear: flags=%b addr=%h data=%h bw=%0d, required all zero",
                     {in_ready, mem_we, cpu_hold, done, err}, mem_addr, mem_data, bytes_written);
        end
        model_bw = 0;
        reset_n  = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || mem_we !== 1'b0 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL midreset_release: ready=%b we=%b hold=%b, required 1 0 0",
                     in_ready, mem_we, cpu_hold);
        end
        d = '{8'h44};
        send_frame(16'h0060, 8'h01, d, 0);
        model_bw += 1;
        #1;
        late = 0;
        foreach (wq[i]) if (wq[i].t >= rc && wq[i].a != 8'h60) late++;
        total++;
        if (late !== 0 || bytes_written !== 16'(model_bw)) begin
            bad++;
            $display("FAIL midreset_after: stray writes=%0d bw=%0d, required 0 %0d",
                     late, bytes_written, model_bw);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_garbage();
        test_sync_in_data();
`ifdef PRG_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_timeout();
        test_random();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
